// File: rtl/mem_x_streamer_if.sv
// Memory read port plus the x-vector stream toward the LSTM datapath.
// master = streamer side, slave = memory/consumer side.
interface mem_x_streamer_if #(
  parameter int WIDTH = 32
);
  logic        [WIDTH-1:0] mem_addr;
  logic signed [WIDTH-1:0] mem_data;
  logic signed [WIDTH-1:0] x_data;
  logic                    x_valid;
  logic                    x_ready;
  logic        [WIDTH-1:0] x_feat;
  logic        [WIDTH-1:0] x_iter;
  logic                    x_last_feat;
  logic                    x_last_iter;

  modport master (
    output mem_addr,
    input  mem_data,
    output x_data, x_valid,
    input  x_ready,
    output x_feat, x_iter, x_last_feat, x_last_iter
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  x_data, x_valid,
    output x_ready,
    input  x_feat, x_iter, x_last_feat, x_last_iter
  );
endinterface

// File: rtl/mem_x_streamer.sv
// Read-side sequencer for the per-timestep LSTM input-vector memory.
// Walks addresses 0..NUM*NUM_ITERATIONS-1 in order, registers each word and
// presents it on a valid/ready stream tagged with feature/timestep indices.
module mem_x_streamer #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 68,
  parameter int NUM_ITERATIONS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  mem_x_streamer_if.master       bus,
  output logic                   busy,
  output logic                   done
);

  localparam logic [WIDTH-1:0] LAST_PTR  = WIDTH'(NUM * NUM_ITERATIONS - 1);
  localparam logic [WIDTH-1:0] FEAT_LAST = WIDTH'(NUM - 1);
  localparam logic [WIDTH-1:0] ITER_LAST = WIDTH'(NUM_ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                  state_q;
  logic        [WIDTH-1:0] rd_ptr_q, feat_q, iter_q;
  logic        [WIDTH-1:0] rd_ptr_d, feat_d, iter_d;
  logic                    all_issued_q;
  logic signed [WIDTH-1:0] x_data_q;
  logic                    x_valid_q;
  logic        [WIDTH-1:0] x_feat_q, x_iter_q;
  logic                    x_last_feat_q, x_last_iter_q;
  logic                    busy_q, done_q;
  logic                    load, xfer;

  // Address comes straight from the running pointer; memory answers same cycle.
  assign bus.mem_addr    = rd_ptr_q;
  assign bus.x_data      = x_data_q;
  assign bus.x_valid     = x_valid_q;
  assign bus.x_feat      = x_feat_q;
  assign bus.x_iter      = x_iter_q;
  assign bus.x_last_feat = x_last_feat_q;
  assign bus.x_last_iter = x_last_iter_q;
  assign busy            = busy_q;
  assign done            = done_q;

  assign load = (state_q == S_STREAM) && (!x_valid_q || bus.x_ready) && !all_issued_q;
  assign xfer = x_valid_q && bus.x_ready;

  // Counter advance: feature wraps into timestep, pointer just increments.
  always_comb begin
    rd_ptr_d = rd_ptr_q + WIDTH'(1);
    feat_d   = feat_q + WIDTH'(1);
    iter_d   = iter_q;
    if (feat_q == FEAT_LAST) begin
      feat_d = '0;
      iter_d = iter_q + WIDTH'(1);
    end
  end

  // Sequencer FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rd_ptr_q      <= '0;
      feat_q        <= '0;
      iter_q        <= '0;
      all_issued_q  <= 1'b0;
      x_data_q      <= '0;
      x_valid_q     <= 1'b0;
      x_feat_q      <= '0;
      x_iter_q      <= '0;
      x_last_feat_q <= 1'b0;
      x_last_iter_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          x_valid_q <= 1'b0;
          done_q    <= 1'b0;
          if (start && !abort) begin
            state_q      <= S_STREAM;
            busy_q       <= 1'b1;
            rd_ptr_q     <= '0;
            feat_q       <= '0;
            iter_q       <= '0;
            all_issued_q <= 1'b0;
          end
        end

        S_STREAM: begin
          if (abort) begin
            // Cancel drops any word on the bus, handshake or not.
            state_q      <= S_IDLE;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            rd_ptr_q     <= '0;
            feat_q       <= '0;
            iter_q       <= '0;
            all_issued_q <= 1'b0;
          end else begin
            if (load) begin
              x_data_q      <= bus.mem_data;
              x_feat_q      <= feat_q;
              x_iter_q      <= iter_q;
              x_last_feat_q <= (feat_q == FEAT_LAST);
              x_last_iter_q <= (iter_q == ITER_LAST);
              x_valid_q     <= 1'b1;
              // Pointer parks on the last address once everything is issued.
              if (rd_ptr_q == LAST_PTR) begin
                all_issued_q <= 1'b1;
              end else begin
                rd_ptr_q <= rd_ptr_d;
                feat_q   <= feat_d;
                iter_q   <= iter_d;
              end
            end else if (xfer) begin
              x_valid_q <= 1'b0;
            end
            if (all_issued_q && xfer) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          x_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          if (abort) begin
            rd_ptr_q     <= '0;
            feat_q       <= '0;
            iter_q       <= '0;
            all_issued_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          x_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
